// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
// Holds the 32-entry integer register file, selects ALU operands and registers
// the rda/rdb/fop/rd bundle for the ALU behind a valid/ready handshake.
// Optional feature: define WB_BYPASS_EN to forward a same-cycle writeback into
// the captured operands. Without it, a same-cycle read returns the old value.
module operand_fetch_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_src,
  input  logic [3:0]      fop_in,
  input  logic [AW-1:0]   rd_in,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rda,
  output logic [XLEN-1:0] rdb,
  output logic [3:0]      fop,
  output logic [AW-1:0]   rd_out
);

  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] rda_q, rda_d;
  logic [XLEN-1:0] rdb_q, rdb_d;
  logic [3:0]      fop_q, fop_d;
  logic [AW-1:0]   rd_q, rd_d;

  logic            accept;
  logic            wb_commit;
  logic [XLEN-1:0] rf_read_a;
  logic [XLEN-1:0] rf_read_b;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign wb_commit = wb_en && (wb_addr != '0);

  assign out_valid = out_valid_q;
  assign rda       = rda_q;
  assign rdb       = rdb_q;
  assign fop       = fop_q;
  assign rd_out    = rd_q;

  // Combinational read ports; x0 always reads as zero regardless of storage.
  always_comb begin
    rf_read_a = '0;
    rf_read_b = '0;
    if (rs1 != '0) rf_read_a = rf_q[rs1];
    if (rs2 != '0) rf_read_b = rf_q[rs2];
  end

  // Operand selection, optionally forwarding the writeback landing this edge.
  always_comb begin
    operand_a = rf_read_a;
    operand_b = alu_src ? imm : rf_read_b;
`ifdef WB_BYPASS_EN
    if (wb_commit && (wb_addr == rs1)) operand_a = wb_data;
    if (!alu_src && wb_commit && (wb_addr == rs2)) operand_b = wb_data;
`endif
  end

  // Register file next state: single write port, writes to x0 are dropped.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      rf_d[i] = rf_q[i];
      if (wb_commit && (wb_addr == AW'(i))) rf_d[i] = wb_data;
    end
  end

  // Pipeline register next state: flush wins, then accept, then drain, else stall.
  always_comb begin
    out_valid_d = out_valid_q;
    rda_d       = rda_q;
    rdb_d       = rdb_q;
    fop_d       = fop_q;
    rd_d        = rd_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      rda_d       = operand_a;
      rdb_d       = operand_b;
      fop_d       = fop_in;
      rd_d        = rd_in;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State update with asynchronous clear of both the bundle and the RF.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_valid_q <= 1'b0;
      rda_q       <= '0;
      rdb_q       <= '0;
      fop_q       <= '0;
      rd_q        <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rda_q       <= rda_d;
      rdb_q       <= rdb_d;
      fop_q       <= fop_d;
      rd_q        <= rd_d;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage
// Directed scenarios followed by random traffic, all checked against a
// behavioural model of the register file and the one-entry output bundle.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        nrst;
  logic        in_valid, in_ready;
  logic [4:0]  rs1, rs2, rd_in, wb_addr, rd_out;
  logic [31:0] imm, wb_data, rda, rdb;
  logic        alu_src, flush, wb_en, out_valid, out_ready;
  logic [3:0]  fop_in, fop;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_rf [32];
  logic        m_valid;
  logic [31:0] m_rda, m_rdb;
  logic [3:0]  m_fop;
  logic [4:0]  m_rd;

  operand_fetch_stage dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .imm(imm), .alu_src(alu_src), .fop_in(fop_in),
    .rd_in(rd_in), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .rda(rda), .rdb(rdb), .fop(fop), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_valid = 1'b0;
    m_rda = '0; m_rdb = '0; m_fop = '0; m_rd = '0;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] a, input logic [4:0] b,
                               input logic [31:0] im, input logic src, input logic [3:0] f,
                               input logic [4:0] rd, input logic fl, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd, input logic ordy);
    in_valid = v; rs1 = a; rs2 = b; imm = im; alu_src = src; fop_in = f;
    rd_in = rd; flush = fl; wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
  endtask

  task automatic checkOutput(input string tag);
    check_eq({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    check_eq({tag, ".rda"}, rda, m_rda);
    check_eq({tag, ".rdb"}, rdb, m_rdb);
    check_eq({tag, ".fop"}, {28'd0, fop}, {28'd0, m_fop});
    check_eq({tag, ".rd_out"}, {27'd0, rd_out}, {27'd0, m_rd});
  endtask

  // One clock: check in_ready, advance the model, clock the DUT, compare bundle.
  task automatic run_cycle(input string tag);
    logic        exp_ready, acc;
    logic [31:0] a, b;
    #1;
    exp_ready = !m_valid || out_ready;
    check_eq({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_ready});
    acc = in_valid && exp_ready;
    a = (rs1 == 0) ? 32'd0 : m_rf[rs1];
    b = (rs2 == 0) ? 32'd0 : m_rf[rs2];
`ifdef WB_BYPASS_EN
    if (wb_en && wb_addr != 0 && wb_addr == rs1) a = wb_data;
    if (wb_en && wb_addr != 0 && wb_addr == rs2) b = wb_data;
`endif
    if (alu_src) b = imm;
    if (flush) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1; m_rda = a; m_rdb = b; m_fop = fop_in; m_rd = rd_in;
    end else if (out_ready) m_valid = 1'b0;
    if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    model_clear();
    nrst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checkOutput("reset");
    check_eq("reset.in_ready", {31'd0, in_ready}, 32'd1);
    #2 nrst = 1'b1;
    @(posedge clk);
    #1;

    // Load x5 and x6, then read them as a register-register bundle.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h0000000A, 1); run_cycle("wb_x5");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 32'h00000005, 1); run_cycle("wb_x6");
    applyStimulus(1, 5, 6, 32'h0, 0, 4'd1, 5'd3, 0, 0, 0, 0, 1); run_cycle("rr_read");
    check_eq("rr_read.rda_const", rda, 32'h0000000A);
    check_eq("rr_read.rdb_const", rdb, 32'h00000005);

    // Writes to x0 vanish and x0 reads as zero.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 1); run_cycle("wb_x0");
    applyStimulus(1, 0, 0, 0, 0, 4'd0, 5'd1, 0, 0, 0, 0, 1); run_cycle("read_x0");
    check_eq("read_x0.rda_const", rda, 32'h0);

    // Immediate operand path.
    applyStimulus(1, 5, 6, 32'hFFFFFFF6, 1, 4'd8, 5'd4, 0, 0, 0, 0, 1); run_cycle("imm_sel");
    check_eq("imm_sel.rdb_const", rdb, 32'hFFFFFFF6);

    // Drain, accept into a stalled consumer, hold for three cycles with a wb to x5.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); run_cycle("drain");
    applyStimulus(1, 5, 6, 0, 0, 4'd0, 5'd9, 0, 0, 0, 0, 0); run_cycle("stall_acc");
    applyStimulus(1, 6, 5, 0, 0, 4'd7, 5'd10, 0, 1, 5, 32'h77, 0); run_cycle("stall1");
    applyStimulus(1, 6, 5, 0, 0, 4'd7, 5'd10, 0, 0, 0, 0, 0); run_cycle("stall2");
    applyStimulus(1, 6, 5, 0, 0, 4'd7, 5'd10, 0, 0, 0, 0, 0); run_cycle("stall3");
    check_eq("stall.rda_const", rda, 32'h0000000A);
    applyStimulus(1, 5, 6, 0, 0, 4'd2, 5'd11, 0, 0, 0, 0, 1); run_cycle("release");
    check_eq("release.rda_const", rda, 32'h00000077);

    // Same-cycle writeback and read of x7.
    applyStimulus(1, 7, 0, 0, 0, 4'd0, 5'd12, 0, 1, 7, 32'h1234, 1); run_cycle("same_wb");
`ifdef WB_BYPASS_EN
    check_eq("same_wb.rda_const", rda, 32'h1234);
`else
    check_eq("same_wb.rda_const", rda, 32'h0);
`endif

    // Flush kills an otherwise accepted bundle; the wb still commits.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); run_cycle("pre_flush");
    applyStimulus(1, 7, 5, 0, 0, 4'd3, 5'd13, 1, 1, 8, 32'hCAFE0001, 1); run_cycle("flush");
    check_eq("flush.out_valid_const", {31'd0, out_valid}, 32'd0);
    applyStimulus(1, 8, 0, 0, 0, 4'd4, 5'd14, 0, 0, 0, 0, 1); run_cycle("after_flush");

    // Asynchronous reset in the middle of a stall.
    applyStimulus(1, 5, 6, 0, 0, 4'd5, 5'd15, 0, 0, 0, 0, 0); run_cycle("stall_b");
    applyStimulus(1, 5, 6, 0, 0, 4'd5, 5'd15, 0, 0, 0, 0, 0); run_cycle("stall_c");
    #2 nrst = 1'b0;
    #1;
    model_clear();
    checkOutput("async_rst");
    #1 nrst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1, 5, 6, 0, 0, 4'd6, 5'd16, 0, 0, 0, 0, 1); run_cycle("rf_cleared");

    // Random traffic, biased so writebacks often target the source registers.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a, b, wa;
      a  = 5'($urandom_range(0, 31));
      b  = 5'($urandom_range(0, 31));
      wa = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      applyStimulus(1'($urandom_range(0, 1)), a, b, $urandom, 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), wa, $urandom,
                    ($urandom_range(0, 3) != 0));
      run_cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
